modexp_ctrl: RTL and testbench

- Sequencing controller that computes base^exponent mod modulus by left-to-right square-and-multiply.
- Drives one shared external multiplier instance (start/in1/in2 → out/finish handshake); owns the accumulator and performs modular reduction itself via a bit-serial shift-subtract reducer.
- Top-level RSA engine block sitting between the key/message registers and the multiplier.

---
 rtl/modexp_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_modexp_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - square-and-multiply modular exponentiation sequencer (optional macro: MODEXP_CONST_TIME_EN)
module modexp_ctrl #(
    parameter int W = 8,
    parameter int E = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   base,
    input  logic [E-1:0]   exponent,
    input  logic [W-1:0]   modulus,
    output logic [W-1:0]   result,
    output logic           busy,
    output logic           done,
    output logic           mult_start,
    output logic [W-1:0]   mult_in1,
    output logic [W-1:0]   mult_in2,
    input  logic [2*W-1:0] mult_out,
    input  logic           mult_finish
);

    localparam int RW = 3 * W;
    localparam int CW = $clog2(2 * W);
    localparam int BW = (E > 1) ? $clog2(E) : 1;
    localparam logic [CW-1:0] RED_LAST = CW'(2 * W - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PREP_RED,
        S_SQ_REQ,
        S_SQ_WAIT,
        S_SQ_RED,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_MUL_RED,
        S_NEXT,
        S_FIN
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_mod;
    logic [E-1:0]   r_exp;
    logic [BW-1:0]  r_bit_cnt;
    logic [W-1:0]   r_acc;
    logic [W-1:0]   r_bm;
    logic [RW-1:0]  r_red;
    logic [CW-1:0]  r_red_cnt;

    logic [W-1:0]   r_result;
    logic           r_busy;
    logic           r_done;
    logic           r_mult_start;
    logic [W-1:0]   r_mult_in1;
    logic [W-1:0]   r_mult_in2;

    logic [RW-1:0]  w_sub;
    logic [RW-1:0]  w_red_step;
    logic           w_red_done;
    logic [W-1:0]   w_red_val;
    logic           w_do_mul;
    logic           w_mod_trivial;

    // One shift-subtract step of the bit-serial reducer; the step index is the count itself
    always_comb begin
        w_sub      = RW'(r_mod) << r_red_cnt;
        w_red_step = (r_red >= w_sub) ? (r_red - w_sub) : r_red;
        w_red_done = (r_red_cnt == '0);
        w_red_val  = w_red_step[W-1:0];
    end

    assign w_mod_trivial = (modulus <= W'(1));

`ifdef MODEXP_CONST_TIME_EN
    // Multiply step runs on every bit so latency does not reveal the exponent
    assign w_do_mul = 1'b1;
`else
    // Multiply step only where the current exponent bit is set
    assign w_do_mul = r_exp[E-1];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_mod_trivial ? S_FIN : S_PREP_RED;
                end
            end
            S_PREP_RED: begin
                if (w_red_done) begin
                    w_next = S_SQ_REQ;
                end
            end
            S_SQ_REQ:  w_next = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mult_finish) begin
                    w_next = S_SQ_RED;
                end
            end
            S_SQ_RED: begin
                if (w_red_done) begin
                    w_next = w_do_mul ? S_MUL_REQ : S_NEXT;
                end
            end
            S_MUL_REQ:  w_next = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mult_finish) begin
                    w_next = S_MUL_RED;
                end
            end
            S_MUL_RED: begin
                if (w_red_done) begin
                    w_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_next = (r_bit_cnt == '0) ? S_FIN : S_SQ_REQ;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, reducer, accumulator and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mod        <= '0;
            r_exp        <= '0;
            r_bit_cnt    <= '0;
            r_acc        <= '0;
            r_bm         <= '0;
            r_red        <= '0;
            r_red_cnt    <= '0;
            r_result     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mult_start <= 1'b0;
            r_mult_in1   <= '0;
            r_mult_in2   <= '0;
        end else begin
            r_busy       <= (w_next != S_IDLE);
            r_done       <= (w_next == S_FIN);
            r_mult_start <= (w_next == S_SQ_REQ) || (w_next == S_MUL_REQ);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mod     <= modulus;
                        r_exp     <= exponent;
                        r_red     <= RW'(base);
                        r_red_cnt <= RED_LAST;
                        if (w_mod_trivial) begin
                            r_result <= '0;
                        end
                    end
                end
                S_PREP_RED: begin
                    r_red     <= w_red_step;
                    r_red_cnt <= r_red_cnt - CW'(1);
                    if (w_red_done) begin
                        r_bm       <= w_red_val;
                        r_acc      <= W'(1);
                        r_bit_cnt  <= BW'(E - 1);
                        r_mult_in1 <= W'(1);
                        r_mult_in2 <= W'(1);
                    end
                end
                S_SQ_WAIT, S_MUL_WAIT: begin
                    if (mult_finish) begin
                        r_red     <= RW'(mult_out);
                        r_red_cnt <= RED_LAST;
                    end
                end
                S_SQ_RED: begin
                    r_red     <= w_red_step;
                    r_red_cnt <= r_red_cnt - CW'(1);
                    if (w_red_done) begin
                        r_acc <= w_red_val;
                        if (w_do_mul) begin
                            r_mult_in1 <= w_red_val;
                            r_mult_in2 <= r_bm;
                        end
                    end
                end
                S_MUL_RED: begin
                    r_red     <= w_red_step;
                    r_red_cnt <= r_red_cnt - CW'(1);
                    // A zero bit only reaches here in constant-time mode; its product is dropped
                    if (w_red_done && r_exp[E-1]) begin
                        r_acc <= w_red_val;
                    end
                end
                S_NEXT: begin
                    if (r_bit_cnt == '0) begin
                        r_result <= r_acc;
                    end else begin
                        r_bit_cnt  <= r_bit_cnt - BW'(1);
                        r_exp      <= r_exp << 1;
                        r_mult_in1 <= r_acc;
                        r_mult_in2 <= r_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result     = r_result;
    assign busy       = r_busy;
    assign done       = r_done;
    assign mult_start = r_mult_start;
    assign mult_in1   = r_mult_in1;
    assign mult_in2   = r_mult_in2;

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - scoreboard bench for modexp_ctrl with a behavioural multiplier
module tb_modexp_ctrl;

    localparam int W = 8;
    localparam int E = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   base = '0;
    logic [E-1:0]   exponent = '0;
    logic [W-1:0]   modulus = '0;
    logic [W-1:0]   result;
    logic           busy;
    logic           done;
    logic           mult_start;
    logic [W-1:0]   mult_in1;
    logic [W-1:0]   mult_in2;
    logic [2*W-1:0] mult_out = '0;
    logic           mult_finish = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int n_mult  = 0;
    bit stab_err = 1'b0;
    int mult_lat = 3;
    bit mult_rand = 1'b0;
    int unsigned sb_q[$];

    modexp_ctrl #(.W(W), .E(E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base),
        .exponent(exponent), .modulus(modulus), .result(result),
        .busy(busy), .done(done), .mult_start(mult_start),
        .mult_in1(mult_in1), .mult_in2(mult_in2),
        .mult_out(mult_out), .mult_finish(mult_finish)
    );

    always #5 clk = ~clk;

    function automatic int unsigned ref_modexp(int unsigned b, int unsigned e, int unsigned m);
        int unsigned r;
        int unsigned bb;
        if (m <= 1) return 0;
        r  = 1;
        bb = b % m;
        for (int i = 0; i < E; i++) begin
            if (((e >> i) & 1) != 0) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Behavioural multiplier: answers each mult_start after a latency, checks operand stability
    initial begin
        logic [W-1:0] c1;
        logic [W-1:0] c2;
        int  lat;
        bit  aborted;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mult_start) begin
                c1 = mult_in1;
                c2 = mult_in2;
                n_mult++;
                lat = mult_rand ? int'($urandom_range(1, 6)) : mult_lat;
                aborted = 1'b0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    #1;
                    if (mult_in1 != c1 || mult_in2 != c2) stab_err = 1'b1;
                end
                if (!aborted) begin
                    @(negedge clk);
                    mult_finish = 1'b1;
                    mult_out    = 16'(c1) * 16'(c2);
                    @(negedge clk);
                    mult_finish = 1'b0;
                end
            end
        end
    end

    // Monitor: every done pulse is matched against the oldest expected result
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: actual result %0d required no done", result);
                end else begin
                    check("result", longint'(result), longint'(sb_q.pop_front()));
                end
            end
        end
    end

    task automatic run_op(input int unsigned b, input int unsigned e, input int unsigned m,
                          input bit inj, output int lat, output int ops);
        int n;
        bit d;
        bit busy_ok;
        int m0;
        busy_ok = 1'b1;
        @(negedge clk);
        base = W'(b); exponent = E'(e); modulus = W'(m); start = 1'b1;
        sb_q.push_back(ref_modexp(b, e, m));
        m0 = n_mult;
        stab_err = 1'b0;
        @(posedge clk);
        #1;
        n = 1;
        d = done;
        if (!busy) busy_ok = 1'b0;
        while (!d && n < 20000) begin
            @(negedge clk);
            start = inj && (n == 5);
            if (start) begin
                base = W'($urandom); exponent = E'($urandom); modulus = W'($urandom_range(2, 255));
            end
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_ok = 1'b0;
            d = done;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_within_budget", d, 1);
        check("busy_high", busy_ok, 1);
        check("mult_in_stable", stab_err, 0);
        lat = n + 1;
        ops = n_mult - m0;
        @(posedge clk);
        #1;
        check("busy_low_after", busy, 0);
        check("done_single_pulse", done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ops, lat1, ops1, lat2, ops2, t, m0;
        int unsigned db[6] = '{3, 57, 2, 200, 9, 9};
        int unsigned de[6] = '{5, 12, 255, 0, 3, 3};
        int unsigned dm[6] = '{7, 13, 255, 77, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mult_start", mult_start, 0);
        check("rst_mult_in1", mult_in1, 0);
        check("rst_mult_in2", mult_in2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(db[i], de[i], dm[i], i == 0, lat, ops);
            if (dm[i] <= 1) begin
                check("trivial_mod_latency", lat, 2);
                check("trivial_mod_ops", ops, 0);
            end
        end

        run_op(5, 8'h80, 251, 1'b0, lat1, ops1);
        run_op(5, 8'hFF, 251, 1'b0, lat2, ops2);
`ifdef MODEXP_CONST_TIME_EN
        check("ops_0x80", ops1, 2 * E);
        check("ops_0xFF", ops2, 2 * E);
        check("latency_equal", lat1, lat2);
`else
        check("ops_0x80", ops1, E + $countones(8'h80));
        check("ops_0xFF", ops2, E + $countones(8'hFF));
        check("latency_differs", lat1 != lat2, 1);
`endif

        // Abort during SQ_WAIT
        @(negedge clk);
        base = 3; exponent = 5; modulus = 7; start = 1'b1;
        sb_q.push_back(ref_modexp(3, 5, 7));
        m0 = n_mult;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (n_mult == m0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("abort_reached_mult", n_mult != m0, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_result", result, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_mult_start", mult_start, 0);
        check("abort_mult_in1", mult_in1, 0);
        check("abort_mult_in2", mult_in2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        repeat (30) @(posedge clk);

        run_op(57, 12, 13, 1'b1, lat, ops);

        mult_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int unsigned rm;
            rm = (i % 7 == 0) ? $urandom_range(0, 3) : $urandom_range(2, 255);
            run_op($urandom_range(0, 255), $urandom_range(0, 255), rm, i[0], lat, ops);
        end
        mult_rand = 1'b0;

        repeat (5) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
